// File: rtl/jam_result_packer.sv
`default_nettype none
// ============================================================================
// Module      : jam_result_packer
// Description : Packs the JAM solver's 8-beat result burst (one job index
//               per worker plus a constant total cost) into a single 43-bit
//               entry {err, cost[9:0], assign[31:0]}. Entries are buffered in
//               a DEPTH-entry FIFO and presented over a valid/ready handshake.
//               Optional feature macro: JAM_PERM_CHECK_EN (flags entries whose
//               jobs are out of range 1..8 or repeat within a burst).
// Revision    : 1.0 - initial release
// ============================================================================
module jam_result_packer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  in_job,
    input  logic [9:0]  in_cost,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_assign,
    output logic [9:0]  out_cost,
    output logic        out_err,
    output logic [7:0]  drop_cnt,
    output logic        busy
);

    localparam int           c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0] c_DEPTH   = (c_AW + 1)'(DEPTH);
    // Beat counter doubles as collector state: 0 = IDLE, 1..7 = COLLECT
    localparam logic [2:0]   c_CNT_IDLE = 3'd0;
    localparam logic [2:0]   c_CNT_LAST = 3'd7;

    // ------------------------------------------------------------------
    // Collector state
    // ------------------------------------------------------------------
    logic [2:0]  r_cnt;
    logic [3:0]  r_slot [0:6];
    logic [9:0]  r_cost;
    logic        r_err;

    logic        w_idle;
    logic        w_last;
    logic        w_cost_mis;
    logic        w_job_bad;
    logic        w_push;
    logic [31:0] w_ent_assign;
    logic        w_ent_err;

    assign w_idle     = (r_cnt == c_CNT_IDLE);
    assign w_last     = (r_cnt == c_CNT_LAST);
    assign w_cost_mis = (in_cost != r_cost);
    // An entry is produced either by the 8th beat or by in_valid dropping mid-burst
    assign w_push     = !w_idle && (!in_valid || w_last);

`ifdef JAM_PERM_CHECK_EN
    logic [7:0] r_mask;
    logic [7:0] w_job_onehot;
    logic       w_in_range;

    assign w_in_range   = (in_job != 4'd0) && (in_job <= 4'd8);
    assign w_job_onehot = w_in_range ? (8'd1 << (in_job - 4'd1)) : 8'd0;
    // First beat of a burst only needs the range check; later beats also look for repeats
    assign w_job_bad    = !w_in_range || (!w_idle && ((r_mask & w_job_onehot) != 8'd0));

    // Seen-job mask, restarted by the first beat of every burst
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= 8'd0;
        end else if (in_valid) begin
            r_mask <= w_idle ? w_job_onehot : (r_mask | w_job_onehot);
        end
    end
`else
    assign w_job_bad = 1'b0;
`endif

    // Assemble the outgoing entry; nibbles past the collected beats stay zero
    always_comb begin
        w_ent_assign = 32'd0;
        for (int k = 0; k < 7; k++) begin
            if (3'(k) < r_cnt) begin
                w_ent_assign[4*k +: 4] = r_slot[k];
            end
        end
        if (in_valid && w_last) begin
            w_ent_assign[31:28] = in_job;
        end
        // A short burst is always an error; a full one carries the accumulated flags
        w_ent_err = !in_valid || r_err || w_cost_mis || w_job_bad;
    end

    // Beat counter, job slots, latched cost and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= c_CNT_IDLE;
            r_cost <= 10'd0;
            r_err  <= 1'b0;
            for (int k = 0; k < 7; k++) begin
                r_slot[k] <= 4'd0;
            end
        end else if (in_valid) begin
            if (w_idle) begin
                r_slot[0] <= in_job;
                r_cost    <= in_cost;
                r_err     <= w_job_bad;
                r_cnt     <= 3'd1;
            end else if (!w_last) begin
                r_slot[r_cnt] <= in_job;
                r_err         <= r_err | w_cost_mis | w_job_bad;
                r_cnt         <= r_cnt + 3'd1;
            end else begin
                r_cnt <= c_CNT_IDLE;
            end
        end else begin
            r_cnt <= c_CNT_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    logic [42:0]     r_mem [0:DEPTH-1];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [7:0]      r_drop;

    logic        w_full;
    logic        w_pop;
    logic        w_push_ok;
    logic [42:0] w_head;

    assign w_full    = (r_count == c_DEPTH);
    assign w_pop     = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_head    = r_mem[r_rd_ptr];

    // Entry storage; contents are masked at the outputs while empty
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {w_ent_err, r_cost, w_ent_assign};
        end
    end

    // Read/write pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Saturating count of entries lost to a full FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= 8'd0;
        end else if (w_push && !w_push_ok && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    assign out_valid  = (r_count != '0);
    assign out_assign = out_valid ? w_head[31:0]  : 32'd0;
    assign out_cost   = out_valid ? w_head[41:32] : 10'd0;
    assign out_err    = out_valid ? w_head[42]    : 1'b0;
    assign drop_cnt   = r_drop;
    assign busy       = !w_idle;

endmodule
`default_nettype wire
